cordic_nco: RTL and testbench
=============================

# cordic_nco

Parametrised numerically-controlled oscillator. A phase accumulator drives a fully pipelined CORDIC rotator. It produces gain-compensated signed sine/cosine with a valid flag travelling alongside each sample. It is the next-generation replacement for the fixed-width quadrature DDS in the signal-generation path. It adds a programmable frequency tuning word, a phase offset, a configurable iteration count and synchronous reset.

## Interface
- `DW`, 16: phase resolution fed to the CORDIC. Output magnitude is DW+1 bits signed.
- `PW`, 32: phase-accumulator width; must satisfy PW ≥ DW.
- `ITER`, 14: number of CORDIC micro-rotation stages; range 4 ≤ ITER ≤ DW-2.
- `clk`, in, 1: single clock. All logic is rising-edge.
- `rst`, in, 1: synchronous, active-high reset.
- `ftw`, in, PW: frequency tuning word, captured on `ftw_load`.
- `ftw_load`, in, 1: latch `ftw` into the internal increment register.
- `poff`, in, PW: phase offset, captured on `ftw_load`.
- `phase_clr`, in, 1: zero the accumulator.
- `en`, in, 1: issue one sample and advance the accumulator.
- `sin`, out, DW+1: signed sine, two's complement.
- `cos`, out, DW+1: signed cosine, two's complement.
- `err`, out, DW+1: residual angle z of the emitted sample, in LSBs.
- `out_valid`, out, 1: high for one cycle per emitted sample.

## Operation
- Registers: `inc` (PW bits), `off` (PW bits), `acc` (PW bits), a valid shift chain of ITER+2 bits, and the x/y/z/quadrant stage registers.
- Edge with `ftw_load`=1: `inc`←`ftw`, `off`←`poff`.
- Edge with `en`=1:
  - Stage 0 captures `ph = (acc + off)[PW-1 -: DW]`, using the pre-edge `acc`, `inc` and `off`.
  - `acc` ← `acc + inc`, mod 2^PW (wraps silently).
- Edge with `phase_clr`=1: `acc`←0. This has priority over the `en` increment. A sample issued on the same edge still uses the old `acc`.
- Quadrant folding:
  - `q = ph[DW-1:DW-2]`.
  - `z0 = {3'b0, ph[DW-3:0]}`, where 2^(DW-2) LSB = π/2.
  - `x0 = round(0.607253·2^(DW-1))` (19898 for DW=16); `y0 = 0`.
- Stage k, for k = 0..ITER-1:
  - If z<0: x += y>>>k, y −= x>>>k, z += A[k].
  - Otherwise: x −= y>>>k, y += x>>>k, z −= A[k].
  - Shifts are arithmetic; all x/y/z are DW+1 bits signed.
- `A[k] = round(atan(2^-k)·2^(DW-1)/π)` is an elaboration-time constant from a constant function. No runtime ROM or initial blocks.
- `q` is delayed alongside the data through every stage.
- Output stage: updates `sin`/`cos`/`err` only when the valid bit at stage ITER is set. Otherwise the outputs hold their last value.
  - q=0: cos=x, sin=y.
  - q=1: cos=−y, sin=x.
  - q=2: cos=−x, sin=−y.
  - q=3: cos=y, sin=−x.
- `out_valid` ← that same valid bit.
- Stage registers clock every cycle. Only the valid chain qualifies the data.

## Timing
- Latency: a sample issued at edge E appears with `out_valid`=1 after edge E+ITER+1, i.e. 15 edges for the defaults.
- Throughput: one sample per cycle. `en` held high gives continuous `out_valid`.
- Reset values: `sin`, `cos`, `err`, `acc`, `inc`, `off`, all valid bits and all stage registers are 0. `out_valid`=0.
- `rst` has priority over every other input on the same edge.
- `rst` mid-stream: all in-flight samples are discarded, and `out_valid` is 0 from the reset edge onward. No sample issued before reset may ever emerge. The first post-reset sample needs a fresh `en`.
- `ftw_load` and `en` on the same edge: the sample and the increment use the old `inc`/`off`. The new values apply from the next edge.
- Accuracy requirement: |sin|,|cos| error ≤ 4 LSB versus ideal 2^(DW-1)·sin/cos of the truncated phase, for ITER=14 and DW=16.

## Test plan
- Reset: hold `rst` 3 cycles with `en`=1 → `out_valid`=0 and `sin`=`cos`=`err`=0 throughout, and for 15 cycles after release when `en`=0.
- DC phase: `ftw_load` with ftw=0, poff=0, then a single `en` pulse at edge E → `out_valid` high only after edge E+15, with cos=32767±4 and sin=0±4.
- Quadrants: poff = 0x4000_0000, 0x8000_0000, 0xC000_0000, one `en` each → (cos,sin) ≈ (0,+32767), (−32767,0), (0,−32767), each ±4.
- Sweep: ftw=0x0100_0000 with `en` held 512 cycles → `out_valid` continuous after 15 cycles. The output sequence has period exactly 256 and sin²+cos² lies within ±0.1% of 32767². `acc` reads 0 after 256 issues.
- Simultaneous controls:
  - `ftw_load` (ftw 0x0100_0000 → 0x0200_0000) coincident with `en` → the next sample's phase step is still 0x0100_0000, then 0x0200_0000.
  - `phase_clr` with `en` → the current sample uses the old phase, and the next sample has phase 0.
- Mid-stream reset: continuous sweep, `rst` for 1 cycle at cycle 100 → `out_valid` falls immediately and stays low until 15 edges after the first post-reset `en`. The first output is cos≈32767.

Source files
------------

// File: rtl/cordic_nco.sv
// cordic_nco: phase accumulator feeding a fully pipelined CORDIC rotator.
// Produces gain-compensated signed sine/cosine of the accumulated phase.
// The output carries the residual angle and a valid flag that travels
// alongside each sample through the pipeline.
module cordic_nco #(
  parameter int DW   = 16,
  parameter int PW   = 32,
  parameter int ITER = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PW-1:0]        ftw,
  input  logic                 ftw_load,
  input  logic [PW-1:0]        poff,
  input  logic                 phase_clr,
  input  logic                 en,
  output logic signed [DW:0]   sin,
  output logic signed [DW:0]   cos,
  output logic signed [DW:0]   err,
  output logic                 out_valid
);

  localparam real PI = 3.14159265358979323846;

  // atan(2^-k) in phase LSBs, where 2^(DW-1) LSB = pi.
  // Uses a power series so that only real arithmetic is needed.
  function automatic int atan_lsb(input int unsigned k);
    real x;
    real xx;
    real term;
    real sum;
    if (k == 0) begin
      sum = PI / 4.0;
    end else begin
      x = 1.0;
      for (int unsigned i = 0; i < k; i++) x = x / 2.0;
      xx   = x * x;
      term = x;
      sum  = 0.0;
      for (int unsigned n = 0; n < 20; n++) begin
        sum  = sum + (((n % 2) == 0) ? term : -term) / real'(2 * n + 1);
        term = term * xx;
      end
    end
    return $rtoi(sum * real'(2 ** (DW - 1)) / PI + 0.5);
  endfunction

  // Packed table of all micro-rotation angles, built at elaboration.
  function automatic logic [ITER*(DW+1)-1:0] build_atan();
    logic [ITER*(DW+1)-1:0] t;
    t = '0;
    for (int unsigned k = 0; k < ITER; k++) begin
      t[k*(DW+1) +: DW+1] = (DW+1)'(atan_lsb(k));
    end
    return t;
  endfunction

  localparam logic [ITER*(DW+1)-1:0] ATAN_TAB = build_atan();
  localparam logic signed [DW:0] X0 =
    (DW+1)'($rtoi(0.607253 * real'(2 ** (DW - 1)) + 0.5));

  logic [PW-1:0]        inc_q;
  logic [PW-1:0]        off_q;
  logic [PW-1:0]        acc_q;
  logic [PW-1:0]        acc_d;
  logic [DW-1:0]        ph_d;

  logic signed [DW:0]   x_q [ITER+1];
  logic signed [DW:0]   y_q [ITER+1];
  logic signed [DW:0]   z_q [ITER+1];
  logic [1:0]           q_q [ITER+1];
  logic [ITER:0]        v_q;

  // Phase presented to stage 0 and next accumulator value (clear beats advance).
  always_comb begin
    ph_d  = DW'((acc_q + off_q) >> (PW - DW));
    acc_d = acc_q;
    if (phase_clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + inc_q;
    end
  end

  // Tuning registers and phase accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      inc_q <= '0;
      off_q <= '0;
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
      if (ftw_load) begin
        inc_q <= ftw;
        off_q <= poff;
      end
    end
  end

  // Quadrant fold into stage 0, then ITER micro-rotation stages; data
  // registers clock every cycle and only the valid chain qualifies them.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k <= ITER; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
        z_q[k] <= '0;
        q_q[k] <= '0;
      end
      v_q <= '0;
    end else begin
      x_q[0] <= X0;
      y_q[0] <= '0;
      z_q[0] <= {3'b000, ph_d[DW-3:0]};
      q_q[0] <= ph_d[DW-1:DW-2];
      v_q    <= {v_q[ITER-1:0], en};
      for (int unsigned k = 0; k < ITER; k++) begin
        if (z_q[k][DW]) begin
          x_q[k+1] <= x_q[k] + (y_q[k] >>> k);
          y_q[k+1] <= y_q[k] - (x_q[k] >>> k);
          z_q[k+1] <= z_q[k] + $signed(ATAN_TAB[k*(DW+1) +: DW+1]);
        end else begin
          x_q[k+1] <= x_q[k] - (y_q[k] >>> k);
          y_q[k+1] <= y_q[k] + (x_q[k] >>> k);
          z_q[k+1] <= z_q[k] - $signed(ATAN_TAB[k*(DW+1) +: DW+1]);
        end
        q_q[k+1] <= q_q[k];
      end
    end
  end

  // Quadrant unfold into the registered outputs; outputs hold between samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sin       <= '0;
      cos       <= '0;
      err       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= v_q[ITER];
      if (v_q[ITER]) begin
        case (q_q[ITER])
          2'd0: begin
            cos <= x_q[ITER];
            sin <= y_q[ITER];
          end
          2'd1: begin
            cos <= -y_q[ITER];
            sin <= x_q[ITER];
          end
          2'd2: begin
            cos <= -x_q[ITER];
            sin <= -y_q[ITER];
          end
          default: begin
            cos <= y_q[ITER];
            sin <= -x_q[ITER];
          end
        endcase
        err <= z_q[ITER];
      end
    end
  end

endmodule

// File: tb/tb_cordic_nco.sv
// Scoreboard bench for cordic_nco: the driver keeps a model of the
// accumulator and queues the ideal sine/cosine for every issued sample;
// the monitor pops and compares each time out_valid is seen.
module tb_cordic_nco;

  localparam int  DW   = 16;
  localparam int  PW   = 32;
  localparam int  ITER = 14;
  localparam int  LAT  = ITER + 1;
  localparam real PI   = 3.14159265358979323846;
  localparam longint FS2    = 64'd1073676289;  // 32767^2
  localparam longint FS2TOL = 64'd1073676;     // 0.1 % of 32767^2

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic                ftw_load;
  logic                phase_clr;
  logic                en;
  logic [PW-1:0]       ftw;
  logic [PW-1:0]       poff;
  logic signed [DW:0]  sin_w;
  logic signed [DW:0]  cos_w;
  logic signed [DW:0]  err_w;
  logic                out_valid;

  cordic_nco #(.DW(DW), .PW(PW), .ITER(ITER)) dut (
    .clk       (clk),
    .rst       (rst),
    .ftw       (ftw),
    .ftw_load  (ftw_load),
    .poff      (poff),
    .phase_clr (phase_clr),
    .en        (en),
    .sin       (sin_w),
    .cos       (cos_w),
    .err       (err_w),
    .out_valid (out_valid)
  );

  typedef struct {
    int c;
    int s;
    int tol;
    int issue;
    int ph;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [31:0] acc_m  = '0;
  logic [31:0] inc_m  = '0;
  logic [31:0] off_m  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string what, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", what, detail);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Queue the ideal response for a sample issued at the coming edge.
  task automatic push_exp();
    logic [31:0] s;
    exp_t        e;
    real         ang;
    s       = acc_m + off_m;
    e.ph    = int'(s[31:16]);
    ang     = 2.0 * PI * real'(e.ph) / 65536.0;
    e.c     = int'(32768.0 * $cos(ang));
    e.s     = int'(32768.0 * $sin(ang));
    e.tol   = (s[29:16] == 14'd0) ? 4 : 12;
    e.issue = cyc + 1;
    sb.push_back(e);
  endtask

  // Apply one cycle of inputs (at the falling edge) and advance the model.
  task automatic drive(input bit r, input bit e, input bit ld,
                       input logic [31:0] f, input logic [31:0] p, input bit clr);
    @(negedge clk);
    rst       = r;
    en        = e;
    ftw_load  = ld;
    ftw       = f;
    poff      = p;
    phase_clr = clr;
    if (r) begin
      acc_m = '0;
      inc_m = '0;
      off_m = '0;
      @(posedge clk);
      #1;
      sb.delete();
    end else begin
      if (e) push_exp();
      if (clr) acc_m = '0;
      else if (e) acc_m = acc_m + inc_m;
      if (ld) begin
        inc_m = f;
        off_m = p;
      end
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < LAT + 10 && sb.size() != 0; i++) begin
      drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    end
    check(sb.size() == 0, "drain",
          $sformatf("%s: %0d samples never emerged", tag, sb.size()));
  endtask

  // Monitor: every valid output must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    exp_t   e;
    longint m;
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check(1'b0, "unexpected_valid",
              $sformatf("out_valid high with nothing pending at cycle %0d", cyc));
      end else begin
        e = sb.pop_front();
        check(cyc - e.issue == LAT, "latency",
              $sformatf("ph=0x%04h got %0d edges, want %0d", e.ph, cyc - e.issue, LAT));
        check(iabs(int'(cos_w) - e.c) <= e.tol, "cos",
              $sformatf("ph=0x%04h got %0d, want %0d +/-%0d", e.ph, cos_w, e.c, e.tol));
        check(iabs(int'(sin_w) - e.s) <= e.tol, "sin",
              $sformatf("ph=0x%04h got %0d, want %0d +/-%0d", e.ph, sin_w, e.s, e.tol));
        check(iabs(int'(err_w)) <= 3, "residual",
              $sformatf("ph=0x%04h got %0d, want |err|<=3", e.ph, err_w));
        m = longint'(cos_w) * longint'(cos_w) + longint'(sin_w) * longint'(sin_w);
        check((m >= FS2 - FS2TOL) && (m <= FS2 + FS2TOL), "magnitude",
              $sformatf("ph=0x%04h got sin^2+cos^2=%0d, want %0d +/-%0d",
                        e.ph, m, FS2, FS2TOL));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: run did not complete by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst = 1'b1; en = 1'b1; ftw_load = 1'b0; phase_clr = 1'b0; ftw = '0; poff = '0;

    // Reset held three cycles with en high, then fifteen idle cycles.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check(out_valid === 1'b0 && sin_w === '0 && cos_w === '0 && err_w === '0,
            "reset_hold", $sformatf("cycle %0d got valid=%b sin=%0d cos=%0d err=%0d, want all 0",
                                    i, out_valid, sin_w, cos_w, err_w));
    end
    rst = 1'b0; en = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      @(posedge clk);
      @(negedge clk);
      check(out_valid === 1'b0 && sin_w === '0 && cos_w === '0 && err_w === '0,
            "reset_idle", $sformatf("cycle %0d got valid=%b sin=%0d cos=%0d err=%0d, want all 0",
                                    i, out_valid, sin_w, cos_w, err_w));
    end

    // DC phase: single sample at zero phase.
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    drain("dc");

    // Quadrant axes via phase offset.
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h4000_0000, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h8000_0000, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'hC000_0000, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    drain("quadrants");

    // Load coincident with issue, then clear coincident with issue.
    drive(1'b0, 1'b0, 1'b1, 32'h0100_0000, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 32'h0200_0000, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    drain("simultaneous");

    // Continuous sweep: two full periods of 256 samples.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'h0100_0000, 32'h0, 1'b0);
    for (int i = 0; i < 512; i++) drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    drain("sweep");

    // Mid-stream reset: in-flight samples must vanish.
    for (int i = 0; i < 100; i++) drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      check(out_valid === 1'b0 && cos_w === '0 && sin_w === '0, "post_reset_quiet",
            $sformatf("cycle %0d after reset got valid=%b cos=%0d sin=%0d, want 0/0/0",
                      i, out_valid, cos_w, sin_w));
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    drain("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
